prbs_gen_par: RTL and testbench
===============================

PRBS_GEN_PAR -- requirements
Module: prbs_gen_par

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning serial PRBS bits emitted per output word (legal range 1..32).
REQ-002 SHALL have parameter MODE_RST, default 3'd1, meaning the polynomial mode after reset (PRBS9).
REQ-003 SHALL have parameter SEED, default 31'h1FF, meaning the LFSR state after reset, masked to the active order.
REQ-004 Ports: clk  in  1  clock; all logic on rising edge.
REQ-005 Ports: rst  in  1  reset; asynchronous, active-high.
REQ-006 Ports: seed_load  in  1  one-cycle pulse that loads seed_in and mode_in.
REQ-007 Ports: seed_in  in  31  new LFSR state, masked to the order of mode_in.
REQ-008 Ports: mode_in  in  3  polynomial select, sampled only on seed_load.
REQ-009 Ports: inj_err  in  1  pulse that inverts data bit 0 of the next word generated.
REQ-010 Ports: out_ready  in  1  consumer accepts data this cycle.
REQ-011 Ports: out_valid  out  1  data holds a valid word.
REQ-012 Ports: data  out  WIDTH  PRBS word; bit 0 is the earliest serial bit.
REQ-013 Ports: lockup  out  1  one-cycle pulse on all-zero state recovery.
REQ-014 Ports: word_cnt  out  32  count of accepted words.

Function
REQ-015 Modes SHALL be: 0 PRBS7 x^7+x^6+1; 1 PRBS9 x^9+x^5+1; 2 PRBS15 x^15+x^14+1; 3 PRBS23 x^23+x^18+1; 4 PRBS31 x^31+x^28+1; 5..7 behave as mode 1.
REQ-016 Each serial step SHALL output s[0], shift right, and insert fb = s[0]^s[n-k] at s[n-1] (n = order, k = middle tap).
REQ-017 The serial sequence SHALL be bit-identical to the single-bit PRBS9 generator when mode=1, WIDTH=1 and the seeds are equal.
REQ-018 A word generation SHALL advance the LFSR by exactly WIDTH steps in one cycle and load data with those WIDTH bits.
REQ-019 Word generation SHALL occur when out_valid=0, or when out_valid=1 and out_ready=1; this gives a throughput of one word per cycle.
REQ-020 While out_valid=1 and out_ready=0, data, the LFSR and word_cnt SHALL hold.
REQ-021 word_cnt SHALL increment on each out_valid&&out_ready cycle and wrap from 2^32-1 to 0.
REQ-022 seed_load SHALL take priority over every other event, with this behaviour at the edge:
  - LFSR <= seed_in masked to order; mode <= mode_in.
  - out_valid <= 0; word_cnt <= 0.
  - Any word pending in that cycle is discarded and not counted.
REQ-023 The first word from a new seed SHALL be valid on the second edge after seed_load; its bit 0 SHALL be seed_in[0].
REQ-024 All-zero recovery SHALL work as follows:
  - Trigger: a word generation is due and the masked LFSR is zero.
  - The LFSR SHALL instead load all-ones masked to the order.
  - out_valid SHALL stay 0 that cycle, and lockup SHALL pulse high for that one cycle.
REQ-025 inj_err SHALL be captured in a sticky flag and applied to the next generated word only; the flag SHALL clear on use or on seed_load.
REQ-026 The LFSR state SHALL never be altered by inj_err.
REQ-027 A simultaneous seed_load and inj_err SHALL discard the injection.

Reset
REQ-028 While rst is high, the following SHALL be forced asynchronously:
  - LFSR = SEED masked to the order of MODE_RST; mode = MODE_RST.
  - out_valid = 0, data = 0, lockup = 0, word_cnt = 0, inject flag = 0.
REQ-029 The first word after rst deasserts SHALL be valid on the first edge after release; all-zero recovery (REQ-024) applies if SEED masks to zero.
REQ-030 A reset asserted mid-transfer SHALL abandon the current word with no partial output.

Structure
REQ-031 Package prbs_pkg SHALL hold the mode encodings, the order and middle-tap table per mode, and the 31-bit mask per mode.
REQ-032 The WIDTH-step unrolled next-state and word computation SHALL be a combinational sub-module prbs_lfsr_step, parameterised by WIDTH.
REQ-033 The top level SHALL contain only registers, handshake logic, recovery, injection and the counter.

Verification
REQ-034 Mode 1, WIDTH=1, seed 0x1FF: bits 0..8 are 1 and bit 9 is 0; period is 511 with 256 ones per period.
REQ-035 Mode 0, WIDTH=8, seed 0x7F: the sequence repeats after 127 bits with 64 ones, and data matches the serial reference packed LSB-first.
REQ-036 out_ready low for 5 cycles mid-stream: data stays stable, word_cnt is unchanged, and no bit is skipped or repeated after resume.
REQ-037 seed_load with seed_in=0, mode 4: lockup pulses once, and the following words equal the PRBS31 stream from all-ones.
REQ-038 inj_err pulsed while out_ready=0: only the next new word has bit 0 inverted, and the following word is error-free.
REQ-039 rst asserted between handshakes: outputs reach reset values immediately, and the stream restarts from SEED with word_cnt=0.

Source files
------------

// File: rtl/prbs_pkg.sv
// PRBS generator shared definitions.
// Mode encodings, per-mode order, middle tap and state mask.
package prbs_pkg;

  typedef enum logic [2:0] {
    MODE_PRBS7  = 3'd0,
    MODE_PRBS9  = 3'd1,
    MODE_PRBS15 = 3'd2,
    MODE_PRBS23 = 3'd3,
    MODE_PRBS31 = 3'd4
  } mode_e;

  // LFSR order n for each mode; 5..7 alias PRBS9
  function automatic logic [4:0] order_of(input logic [2:0] m);
    logic [4:0] n;
    case (m)
      MODE_PRBS7:  n = 5'd7;
      MODE_PRBS9:  n = 5'd9;
      MODE_PRBS15: n = 5'd15;
      MODE_PRBS23: n = 5'd23;
      MODE_PRBS31: n = 5'd31;
      default:     n = 5'd9;
    endcase
    return n;
  endfunction

  // Middle tap k of x^n + x^k + 1
  function automatic logic [4:0] tap_of(input logic [2:0] m);
    logic [4:0] k;
    case (m)
      MODE_PRBS7:  k = 5'd6;
      MODE_PRBS9:  k = 5'd5;
      MODE_PRBS15: k = 5'd14;
      MODE_PRBS23: k = 5'd18;
      MODE_PRBS31: k = 5'd28;
      default:     k = 5'd5;
    endcase
    return k;
  endfunction

  // Mask covering the n active state bits
  function automatic logic [30:0] mask_of(input logic [2:0] m);
    logic [30:0] v;
    case (m)
      MODE_PRBS7:  v = 31'h0000_007F;
      MODE_PRBS9:  v = 31'h0000_01FF;
      MODE_PRBS15: v = 31'h0000_7FFF;
      MODE_PRBS23: v = 31'h007F_FFFF;
      MODE_PRBS31: v = 31'h7FFF_FFFF;
      default:     v = 31'h0000_01FF;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/prbs_lfsr_step.sv
// Unrolled WIDTH-step Fibonacci LFSR advance.
// Emits s[0] each step, shifts right, feeds s[0]^s[n-k] into s[n-1].
module prbs_lfsr_step
  import prbs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [30:0]      state,
  input  logic [2:0]       mode,
  output logic [30:0]      next_state,
  output logic [WIDTH-1:0] word
);

  logic [30:0] s;
  logic [4:0]  hi;
  logic [4:0]  tp;
  logic        fb;

  // Serial steps laid out combinationally, earliest bit in word[0]
  always_comb begin
    hi   = order_of(mode) - 5'd1;
    tp   = order_of(mode) - tap_of(mode);
    s    = state & mask_of(mode);
    word = '0;
    fb   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      word[i] = s[0];
      fb      = s[0] ^ s[tp];
      s       = s >> 1;
      s[hi]   = fb;
    end
    next_state = s;
  end

endmodule

// File: rtl/prbs_gen_par.sv
// Parallel PRBS word generator with valid/ready output.
// Handles reseeding, all-zero recovery, error injection, word count.
module prbs_gen_par
  import prbs_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter logic [2:0]  MODE_RST = 3'd1,
  parameter logic [30:0] SEED     = 31'h1FF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [30:0]      seed_in,
  input  logic [2:0]       mode_in,
  input  logic             inj_err,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] data,
  output logic             lockup,
  output logic [31:0]      word_cnt
);

  logic [30:0]      lfsr;
  logic [2:0]       mode;
  logic             inj_flag;
  logic [30:0]      nxt;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] flip;
  logic             gen;
  logic             zero;
  logic             inj_now;

  prbs_lfsr_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .state     (lfsr),
    .mode      (mode),
    .next_state(nxt),
    .word      (word)
  );

  assign gen     = !out_valid || out_ready;
  assign zero    = (lfsr & mask_of(mode)) == 31'd0;
  assign inj_now = inj_flag || inj_err;
  assign flip    = WIDTH'(inj_now);

  // LFSR, output word, recovery and injection state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr      <= SEED & mask_of(MODE_RST);
      mode      <= MODE_RST;
      out_valid <= 1'b0;
      data      <= '0;
      lockup    <= 1'b0;
      inj_flag  <= 1'b0;
    end else begin
      lockup <= 1'b0;
      if (seed_load) begin
        lfsr      <= seed_in & mask_of(mode_in);
        mode      <= mode_in;
        out_valid <= 1'b0;
        inj_flag  <= 1'b0;
      end else if (gen && zero) begin
        lfsr      <= mask_of(mode);
        out_valid <= 1'b0;
        lockup    <= 1'b1;
        inj_flag  <= inj_now;
      end else if (gen) begin
        lfsr      <= nxt;
        data      <= word ^ flip;
        out_valid <= 1'b1;
        inj_flag  <= 1'b0;
      end else begin
        inj_flag  <= inj_now;
      end
    end
  end

  // Accepted-word counter, cleared by reseed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (seed_load) begin
      word_cnt <= '0;
    end else if (out_valid && out_ready) begin
      word_cnt <= word_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_prbs_gen_par.sv
// Scoreboard bench for prbs_gen_par.
// Reference model is a bit-recurrence queue b[t+n] = b[t] ^ b[t+n-k].
module tb_prbs_gen_par;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          seed_load;
  logic [30:0]   seed_in;
  logic [2:0]    mode_in;
  logic          inj_err;
  logic          out_ready;
  logic          out_valid;
  logic [W-1:0]  data;
  logic          lockup;
  logic [31:0]   word_cnt;

  always #5 clk = ~clk;

  prbs_gen_par #(
    .WIDTH   (W),
    .MODE_RST(3'd1),
    .SEED    (31'h1FF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .seed_load(seed_load),
    .seed_in  (seed_in),
    .mode_in  (mode_in),
    .inj_err  (inj_err),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .data     (data),
    .lockup   (lockup),
    .word_cnt (word_cnt)
  );

  int checks   = 0;
  int failures = 0;

  bit           bq[$];
  int           m_n;
  int           m_k;
  bit           m_valid;
  bit           m_lock;
  bit           m_inj;
  logic [31:0]  m_cnt;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic void set_mode(input logic [2:0] m);
    case (m)
      3'd0:    begin m_n = 7;  m_k = 6;  end
      3'd1:    begin m_n = 9;  m_k = 5;  end
      3'd2:    begin m_n = 15; m_k = 14; end
      3'd3:    begin m_n = 23; m_k = 18; end
      3'd4:    begin m_n = 31; m_k = 28; end
      default: begin m_n = 9;  m_k = 5;  end
    endcase
  endfunction

  function automatic void load_state(input logic [30:0] v);
    bq.delete();
    for (int i = 0; i < m_n; i++) bq.push_back(v[i]);
  endfunction

  function automatic bit all_zero();
    foreach (bq[i]) if (bq[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit next_bit();
    bit b;
    bit o;
    b = bq[0] ^ bq[m_n - m_k];
    o = bq.pop_front();
    bq.push_back(b);
    return o;
  endfunction

  function automatic void model_reset();
    set_mode(3'd1);
    load_state(31'h1FF);
    m_valid = 1'b0;
    m_lock  = 1'b0;
    m_inj   = 1'b0;
    m_cnt   = '0;
    exp_q.delete();
  endfunction

  function automatic void model_edge();
    logic [W-1:0] w;
    if (seed_load) begin
      set_mode(mode_in);
      load_state(seed_in);
      m_valid = 1'b0;
      m_lock  = 1'b0;
      m_inj   = 1'b0;
      m_cnt   = '0;
      exp_q.delete();
      return;
    end
    m_lock = 1'b0;
    if (m_valid && out_ready) m_cnt = m_cnt + 32'd1;
    m_inj = m_inj | inj_err;
    if (!m_valid || out_ready) begin
      if (all_zero()) begin
        foreach (bq[i]) bq[i] = 1'b1;
        m_valid = 1'b0;
        m_lock  = 1'b1;
      end else begin
        for (int i = 0; i < W; i++) w[i] = next_bit();
        if (m_inj) w[0] = ~w[0];
        m_inj = 1'b0;
        exp_q.push_back(w);
        m_valid = 1'b1;
      end
    end
  endfunction

  // Monitor: compare status every cycle, pop a word on each handshake
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("lockup", 32'(lockup), 32'(m_lock));
      chk("word_cnt", word_cnt, m_cnt);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL data_unexpected actual=%h required=none", data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("data", 32'(data), 32'(mon_e));
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic step(input bit rdy, input bit inj, input bit ld,
                      input logic [30:0] s, input logic [2:0] m);
    out_ready = rdy;
    inj_err   = inj;
    seed_load = ld;
    seed_in   = s;
    mode_in   = m;
    cycle();
    inj_err   = 1'b0;
    seed_load = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, 32'(data), 32'd0);
    chk({tag, "_lockup"}, 32'(lockup), 32'd0);
    chk({tag, "_cnt"}, word_cnt, 32'd0);
  endtask

  initial begin
    logic [30:0] s;
    rst       = 1'b1;
    seed_load = 1'b0;
    seed_in   = '0;
    mode_in   = '0;
    inj_err   = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Default PRBS9 stream, random backpressure and injections
    repeat (40)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
           1'b0, '0, '0);

    // PRBS7 from all-ones, several full periods
    step(1'b1, 1'b0, 1'b1, 31'h7F, 3'd0);
    repeat (40) step(1'b1, 1'b0, 1'b0, '0, '0);

    // Five-cycle stall mid-stream then resume
    repeat (5) step(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (10) step(1'b1, 1'b0, 1'b0, '0, '0);

    // Injection while stalled
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (6) step(1'b1, 1'b0, 1'b0, '0, '0);

    // Zero seed in PRBS31 forces recovery
    step(1'b1, 1'b0, 1'b1, 31'h0, 3'd4);
    repeat (20) step(1'b1, 1'b0, 1'b0, '0, '0);

    // Reseed with simultaneous injection drops the injection
    step(1'b1, 1'b1, 1'b1, 31'h1234, 3'd2);
    repeat (10) step(1'b1, 1'b0, 1'b0, '0, '0);

    // Random mix of modes, seeds, stalls and injections
    for (int i = 0; i < 300; i++) begin
      s = 31'($urandom());
      if ($urandom_range(0, 3) == 0) s = '0;
      step($urandom_range(0, 9) < 7, $urandom_range(0, 12) == 0,
           $urandom_range(0, 39) == 0, s, 3'($urandom_range(0, 7)));
    end

    // Asynchronous reset between edges
    step(1'b1, 1'b0, 1'b0, '0, '0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
    repeat (20) step(1'b1, 1'b0, 1'b0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
